// File: rtl/dice_roller_pkg.sv
// Shared types and helpers for the dice roller: FSM states, seven-segment table,
// die side-count width and result-width function.
package dice_roller_pkg;

    localparam int SIDE_W = 7;

    typedef enum logic [1:0] {
        SHOW = 2'd0,
        SPIN = 2'd1,
        SUM  = 2'd2,
        CONV = 2'd3
    } state_e;

    // Active-high {g..a} patterns for digits 0-9.
    localparam logic [6:0] SEG7_TABLE [10] = '{
        7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66,
        7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f
    };

    function automatic int sum_w(input int max_dice);
        return $clog2(max_dice * 100 + 1);
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        if (d < 4'd10) return SEG7_TABLE[d];
        return 7'h00;
    endfunction

endpackage

// File: rtl/dice_roller_mux_bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter; one input bit per clock, so the
// final BCD value is presented on bcd_o in the cycle done_o is high.
module bin2bcd_seq
    import dice_roller_pkg::*;
#(
    parameter int BIN_W = 7,
    parameter int NDIG  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [BIN_W-1:0]  bin_i,
    output logic              done_o,
    output logic [4*NDIG-1:0] bcd_o
);

    localparam int CW = $clog2(BIN_W + 1);

    logic [BIN_W-1:0]  bin_q;
    logic [4*NDIG-1:0] bcd_q;
    logic [CW-1:0]     cnt_q;
    logic [4*NDIG-1:0] adj;
    logic [4*NDIG-1:0] step_bcd;

    always_comb begin
        adj = bcd_q;
        for (int d = 0; d < NDIG; d++) begin
            if (adj[4*d +: 4] >= 4'd5) adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
        end
        step_bcd = (4*NDIG)'({adj, bin_q[BIN_W-1]});
    end

    assign bcd_o  = step_bcd;
    assign done_o = (cnt_q == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else if (start_i) begin
            bin_q <= bin_i;
            bcd_q <= '0;
            cnt_q <= CW'(BIN_W);
        end else if (cnt_q != '0) begin
            bin_q <= bin_q << 1;
            bcd_q <= step_bcd;
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/dice_roller_mux.sv
// Multi-button dice roller with scanned N-digit BCD display; hold time sets the roll.
// Build macro DICE_ROLLER_MULTI_EN adds the ndice port for several dice per roll.
//  state | meaning
//  SHOW  | idle, display scanning, waits for any die button
//  SPIN  | odometer counters step while the chosen button stays high
//  SUM   | adds one die value (cnt+1) per cycle
//  CONV  | binary-to-BCD conversion of the sum, then result update
module dice_roller_mux
    import dice_roller_pkg::*;
#(
    parameter int                     NBTN     = 7,
    parameter logic [SIDE_W*NBTN-1:0] SIDES    = {7'd100, 7'd20, 7'd12, 7'd10, 7'd8, 7'd6, 7'd4},
    parameter int                     NDIGITS  = 3,
    parameter int                     SCAN_DIV = 16,
    parameter int                     MAX_DICE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NBTN-1:0]      btn,
`ifdef DICE_ROLLER_MULTI_EN
    input  logic [2:0]           ndice,
`endif
    input  logic                 seg_pol,
    input  logic                 com_pol,
    output logic [7:0]           seg,
    output logic [NDIGITS-1:0]   com,
    output logic                 busy,
    output logic [4*NDIGITS-1:0] result_bcd,
    output logic                 result_valid
);

`ifdef DICE_ROLLER_MULTI_EN
    localparam int         MAXD  = MAX_DICE;
    localparam logic [2:0] MAXD3 = 3'(MAX_DICE);
`else
    // Single die only; MAX_DICE is accepted but has no effect in this build.
    localparam int MAXD = (MAX_DICE > 0) ? 1 : 1;
`endif
    localparam int SUM_W  = sum_w(MAXD);
    localparam int IDX_W  = (NBTN > 1) ? $clog2(NBTN) : 1;
    localparam int K_W    = (MAXD > 1) ? $clog2(MAXD) : 1;
    localparam int SCAN_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int DIV_W  = $clog2(SCAN_DIV + 1);

    function automatic int max_side();
        int m = 0;
        for (int i = 0; i < NBTN; i++) begin
            if (int'(SIDES[SIDE_W*i +: SIDE_W]) > m) m = int'(SIDES[SIDE_W*i +: SIDE_W]);
        end
        return m;
    endfunction

    if (MAXD * max_side() > 10**NDIGITS - 1) begin : g_range_err
        $error("dice_roller_mux: largest possible sum does not fit in NDIGITS digits");
    end

    state_e                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [SIDE_W-1:0]           side_q, side_d;
    logic [2:0]                  n_q, n_d;
    logic [MAXD-1:0][SIDE_W-1:0] cnt_q, cnt_d;
    logic [K_W-1:0]              k_q, k_d;
    logic [SUM_W-1:0]            acc_q, acc_d;
    logic [4*NDIGITS-1:0]        result_q, result_d;
    logic                        valid_q, valid_d;
    logic [SCAN_W-1:0]           scan_q, scan_d;
    logic [DIV_W-1:0]            div_q, div_d;

    logic [IDX_W-1:0]            low_idx;
    logic [2:0]                  n_sel;
    logic                        carry;
    logic                        conv_start;
    logic                        conv_done;
    logic [4*NDIGITS-1:0]        conv_bcd;

    always_comb begin
        low_idx = '0;
        for (int i = NBTN - 1; i >= 0; i--) begin
            if (btn[i]) low_idx = IDX_W'(i);
        end
    end

    always_comb begin
`ifdef DICE_ROLLER_MULTI_EN
        if (ndice == 3'd0)      n_sel = 3'd1;
        else if (ndice > MAXD3) n_sel = MAXD3;
        else                    n_sel = ndice;
`else
        n_sel = 3'd1;
`endif
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        side_d     = side_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        acc_d      = acc_q;
        result_d   = result_q;
        valid_d    = 1'b0;
        conv_start = 1'b0;
        carry      = 1'b1;
        case (state_q)
            SHOW: begin
                if (|btn) begin
                    state_d = SPIN;
                    idx_d   = low_idx;
                    side_d  = SIDES[SIDE_W*int'(low_idx) +: SIDE_W];
                    n_d     = n_sel;
                    for (int k = 0; k < MAXD; k++) cnt_d[k] = side_d - 7'd1;
                end
            end
            SPIN: begin
                if (btn[idx_q]) begin
                    // Odometer: a die advances only when every lower die wraps this cycle.
                    for (int k = 0; k < MAXD; k++) begin
                        if (carry) cnt_d[k] = (cnt_q[k] == '0) ? side_q - 7'd1 : cnt_q[k] - 7'd1;
                        carry = carry & (cnt_q[k] == '0);
                    end
                end else begin
                    state_d = SUM;
                    k_d     = '0;
                    acc_d   = '0;
                end
            end
            SUM: begin
                acc_d = acc_q + SUM_W'(cnt_q[k_q]) + SUM_W'(1);
                if (3'(k_q) == n_q - 3'd1) begin
                    state_d    = CONV;
                    conv_start = 1'b1;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            CONV: begin
                if (conv_done) begin
                    state_d  = SHOW;
                    result_d = conv_bcd;
                    valid_d  = 1'b1;
                end
            end
            default: state_d = SHOW;
        endcase
    end

    always_comb begin
        div_d  = div_q;
        scan_d = scan_q;
        if (state_q == SHOW) begin
            if (div_q == DIV_W'(SCAN_DIV - 1)) begin
                div_d  = '0;
                scan_d = (scan_q == SCAN_W'(NDIGITS - 1)) ? '0 : scan_q + SCAN_W'(1);
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SHOW;
            idx_q    <= '0;
            side_q   <= '0;
            n_q      <= 3'd1;
            cnt_q    <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            result_q <= (4*NDIGITS)'(1);
            valid_q  <= 1'b0;
            scan_q   <= '0;
            div_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            side_q   <= side_d;
            n_q      <= n_d;
            cnt_q    <= cnt_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            scan_q   <= scan_d;
            div_q    <= div_d;
        end
    end

    bin2bcd_seq #(
        .BIN_W (SUM_W),
        .NDIG  (NDIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (conv_start),
        .bin_i   (acc_d),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    logic [NDIGITS-1:0] blank;
    logic [NDIGITS-1:0] onehot;
    logic [7:0]         pattern;
    logic               higher_zero;

    // Leading-zero suppression: digit 0 is never blanked.
    always_comb begin
        blank       = '0;
        higher_zero = 1'b1;
        for (int j = NDIGITS - 1; j >= 1; j--) begin
            higher_zero = higher_zero & (result_q[4*j +: 4] == 4'd0);
            blank[j]    = higher_zero;
        end
        onehot  = '0;
        pattern = '0;
        if (state_q == SHOW && !blank[scan_q]) begin
            onehot[scan_q] = 1'b1;
            pattern        = {1'b0, seg7(result_q[4*int'(scan_q) +: 4])};
        end
    end

    assign seg          = seg_pol ? pattern : ~pattern;
    assign com          = com_pol ? onehot : ~onehot;
    assign busy         = (state_q != SHOW);
    assign result_bcd   = result_q;
    assign result_valid = valid_q;

endmodule
